irq_controller: RTL and testbench

//  Prioritised 68000 interrupt controller for the fx68k system bus. Replaces ad-hoc IRQ flag logic.

---
 rtl/irq_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_irq_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller -- prioritised 68000 interrupt controller for the fx68k bus.
//
// Seven sources, each synchronised and edge- or level-qualified, feed a
// PENDING register. Enabled pending sources are priority-encoded onto the
// active-low IPL lines. CPU interrupt-acknowledge cycles are answered with
// an autovector (VPA) request, and a small register bank gives the CPU
// access to the pending, enable, edge and status state.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   src[6:0]        raw interrupt sources, src[i] is priority level i+1
//   cs, wr, address register bank select, byte strobes {upper,lower}, word index
//   din, dout       register write data / combinational read data
//   cpu_fc          CPU function code (3'b111 marks an IACK cycle)
//   cpu_as_n        CPU address strobe
//   cpu_lvl         level being acknowledged (cpu_addr[3:1])
//   ipl_n           encoded active-low interrupt priority level
//   vpa_n           active-low autovector request

// Per-source slice: synchroniser, edge detector and pending flop.
// Ports:
//   src        raw asynchronous input
//   edge_mode  1 = rising-edge latched, 0 = level (pending follows input)
//   set_force  software set (edge mode only)
//   clr        W1C / IACK clear; a same-cycle set wins
//   pending    pending view for this source
module irq_src #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic edge_mode,
  input  logic set_force,
  input  logic clr,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_prev;
  logic                   rise;
  logic                   pend_q;
  logic                   pend_next;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_prev;

  // Latched bit is held at 0 in level mode so stale state cannot surface
  // when the source is later switched to edge mode.
  always_comb begin
    pend_next = pend_q;
    if (!edge_mode)
      pend_next = 1'b0;
    else if (rise || set_force)
      pend_next = 1'b1;
    else if (clr)
      pend_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      s_prev <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync[0] <= src;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync[i] <= sync[i-1];
      s_prev <= s;
      pend_q <= pend_next;
    end
  end

  // Level-mode sources are seen straight from the synchroniser, which saves
  // a cycle of latency on both assertion and release.
  assign pending = edge_mode ? pend_q : s;

endmodule

module irq_controller #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [6:0] ENABLE_RESET = 7'h00,
  parameter logic [6:0] EDGE_RESET   = 7'h7F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  src,
  input  logic        cs,
  input  logic [1:0]  wr,
  input  logic [2:0]  address,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic [2:0]  cpu_fc,
  input  logic        cpu_as_n,
  input  logic [2:0]  cpu_lvl,
  output logic [2:0]  ipl_n,
  output logic        vpa_n
);

  localparam int NUM_SRC = 7;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_ENABLE  = 3'd1;
  localparam logic [2:0] REG_EDGE    = 3'd2;
  localparam logic [2:0] REG_FORCE   = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_SPURCLR = 3'd5;

  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] edge_mode;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] force_set;
  logic [NUM_SRC-1:0] iack_clr;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] ack_sel;
  logic [7:0]         lvl_dec;
  logic [2:0]         target;
  logic [2:0]         last_ack;
  logic [7:0]         spurious;
  logic [1:0]         state;
  logic               reg_wr;
  logic               iack_start;
  logic               in_ack;
  logic               ack_hit;
  logic               unused_bits;

  // Only the low byte carries state; the rest of the bus is ignored.
  assign unused_bits = ^{wr[1], din[15:7], lvl_dec[0]};

  assign reg_wr     = cs & wr[0];
  assign w1c        = (reg_wr && address == REG_PENDING) ? din[6:0] : '0;
  assign force_set  = (reg_wr && address == REG_FORCE)   ? din[6:0] : '0;

  assign iack_start = (state == IDLE) && !cpu_as_n && (cpu_fc == 3'b111);
  assign in_ack     = (state == ACK);

  // One-hot of the acknowledged level; level 0 decodes to no source, so it
  // always counts as spurious.
  assign lvl_dec  = 8'd1 << cpu_lvl;
  assign ack_sel  = lvl_dec[7:1];
  assign ack_hit  = |(ack_sel & pending);
  assign iack_clr = in_ack ? (ack_sel & pending) : '0;
  assign clr      = w1c | iack_clr;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_src #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_src (
      .clk       (clk),
      .reset     (reset),
      .src       (src[i]),
      .edge_mode (edge_mode[i]),
      .set_force (force_set[i]),
      .clr       (clr[i]),
      .pending   (pending[i])
    );
  end

  assign active = pending & enable;

  // Ascending scan: the highest active source overwrites lower ones.
  always_comb begin
    target = 3'd0;
    for (int i = 0; i < NUM_SRC; i++)
      if (active[i])
        target = 3'(i + 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable    <= ENABLE_RESET;
      edge_mode <= EDGE_RESET;
      spurious  <= 8'h00;
      last_ack  <= 3'd0;
      state     <= IDLE;
      ipl_n     <= 3'b111;
      vpa_n     <= 1'b1;
    end else begin
      if (reg_wr) begin
        case (address)
          REG_ENABLE: enable    <= din[6:0];
          REG_EDGE:   edge_mode <= din[6:0];
          default: ;
        endcase
      end

      // A spurious ack in the same cycle as SPURCLR is still counted.
      if (in_ack && !ack_hit) begin
        if (spurious != 8'hFF)
          spurious <= spurious + 8'd1;
      end else if (reg_wr && address == REG_SPURCLR) begin
        spurious <= 8'h00;
      end

      case (state)
        IDLE: begin
          if (iack_start)
            state <= ACK;
        end
        ACK: begin
          last_ack <= cpu_lvl;
          vpa_n    <= 1'b0;
          state    <= HOLD;
        end
        HOLD: begin
          if (cpu_as_n) begin
            vpa_n <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // IPL is frozen for the whole acknowledge so the CPU never sees a
      // lower level appear while it is still servicing the current one.
      if (state == IDLE && !iack_start)
        ipl_n <= ~target;
    end
  end

  always_comb begin
    dout = 16'h0000;
    case (address)
      REG_PENDING: dout = {9'd0, pending};
      REG_ENABLE:  dout = {9'd0, enable};
      REG_EDGE:    dout = {9'd0, edge_mode};
      REG_STATUS:  dout = {spurious, 1'b0, last_ack, 1'b0, target};
      default:     dout = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a register access table followed by
// hand-written sequences for edge latency, priority, level mode, set/clear
// collision, masking/force and reset during an acknowledge.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  src;
  logic        cs;
  logic [1:0]  wr;
  logic [2:0]  address;
  logic [15:0] din;
  logic [15:0] dout;
  logic [2:0]  cpu_fc;
  logic        cpu_as_n;
  logic [2:0]  cpu_lvl;
  logic [2:0]  ipl_n;
  logic        vpa_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_controller dut (
    .clk      (clk),
    .reset    (reset),
    .src      (src),
    .cs       (cs),
    .wr       (wr),
    .address  (address),
    .din      (din),
    .dout     (dout),
    .cpu_fc   (cpu_fc),
    .cpu_as_n (cpu_as_n),
    .cpu_lvl  (cpu_lvl),
    .ipl_n    (ipl_n),
    .vpa_n    (vpa_n)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [1:0]  strobe;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [1:0] s, input logic [15:0] d);
    cs = 1'b1; wr = s; address = a; din = d;
    tick(1);
    cs = 1'b0; wr = 2'b00; din = 16'h0000;
  endtask

  task automatic reg_read(input logic [2:0] a, input logic [15:0] exp, input string nm);
    address = a;
    #1;
    chk(nm, dout, exp);
  endtask

  // Full acknowledge of one level; ipl_n must stay at ipl_hold throughout.
  task automatic iack(input logic [2:0] lvl, input logic [2:0] ipl_hold, input string nm);
    cpu_fc = 3'b111; cpu_lvl = lvl; cpu_as_n = 1'b0;
    tick(1);
    chk({nm, "_vpa_ack"}, 16'(vpa_n), 16'h1);
    tick(1);
    chk({nm, "_vpa_low"}, 16'(vpa_n), 16'h0);
    chk({nm, "_ipl_frz1"}, 16'(ipl_n), 16'(ipl_hold));
    tick(1);
    chk({nm, "_vpa_hold"}, 16'(vpa_n), 16'h0);
    chk({nm, "_ipl_frz2"}, 16'(ipl_n), 16'(ipl_hold));
    cpu_as_n = 1'b1; cpu_fc = 3'b000;
    tick(1);
    chk({nm, "_vpa_rel"}, 16'(vpa_n), 16'h1);
    tick(1);
  endtask

  initial begin
    reset = 1'b1; src = '0; cs = 1'b0; wr = 2'b00; address = 3'd0; din = 16'h0;
    cpu_fc = 3'b000; cpu_as_n = 1'b1; cpu_lvl = 3'd0;

    vecs[0] = '{3'd1, 2'b01, 16'h0055, 16'h0055, "en_wr"};
    vecs[1] = '{3'd2, 2'b01, 16'h000F, 16'h000F, "edge_wr"};
    vecs[2] = '{3'd1, 2'b10, 16'h007F, 16'h0055, "en_upper_ignored"};
    vecs[3] = '{3'd1, 2'b01, 16'hFFAA, 16'h002A, "en_mask"};
    vecs[4] = '{3'd3, 2'b01, 16'h0000, 16'h0000, "force_reads0"};
    vecs[5] = '{3'd6, 2'b01, 16'hFFFF, 16'h0000, "reg6"};
    vecs[6] = '{3'd7, 2'b01, 16'hFFFF, 16'h0000, "reg7"};
    vecs[7] = '{3'd5, 2'b01, 16'h1234, 16'h0000, "spurclr_reads0"};
    vecs[8] = '{3'd2, 2'b01, 16'h007F, 16'h007F, "edge_restore"};
    vecs[9] = '{3'd1, 2'b01, 16'h0000, 16'h0000, "en_restore"};

    // 1: reset
    tick(2);
    reset = 1'b0;
    chk("rst_ipl", 16'(ipl_n), 16'h7);
    chk("rst_vpa", 16'(vpa_n), 16'h1);
    reg_read(3'd0, 16'h0000, "rst_pending");
    reg_read(3'd1, 16'h0000, "rst_enable");
    reg_read(3'd2, 16'h007F, "rst_edge");
    reg_read(3'd4, 16'h0000, "rst_status");

    // register table
    foreach (vecs[i]) begin
      reg_write(vecs[i].addr, vecs[i].strobe, vecs[i].wdata);
      reg_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // 2: single edge, latency SYNC_STAGES+2, then acknowledge
    reg_write(3'd1, 2'b01, 16'h0002);
    src[1] = 1'b1;
    tick(1);
    src[1] = 1'b0;
    tick(2);
    chk("edge_ipl_early", 16'(ipl_n), 16'h7);
    tick(1);
    chk("edge_ipl", 16'(ipl_n), 16'h5);
    reg_read(3'd0, 16'h0002, "edge_pending_held");
    iack(3'd2, 3'b101, "ack2");
    chk("ack2_ipl", 16'(ipl_n), 16'h7);
    reg_read(3'd0, 16'h0000, "ack2_pending");
    reg_read(3'd4, 16'h0020, "ack2_status");

    // 3: priority between two simultaneous edges
    reg_write(3'd1, 2'b01, 16'h007F);
    src = 7'b001_0001;
    tick(4);
    chk("prio_ipl", 16'(ipl_n), 16'(3'b010));
    reg_read(3'd0, 16'h0011, "prio_pending");
    iack(3'd5, 3'b010, "ack5");
    chk("ack5_ipl", 16'(ipl_n), 16'(3'b110));
    reg_read(3'd4, 16'h0051, "ack5_status");
    iack(3'd1, 3'b110, "ack1");
    chk("ack1_ipl", 16'(ipl_n), 16'h7);
    src = '0;
    tick(3);
    reg_read(3'd0, 16'h0000, "prio_pending_clr");

    // 4: level mode
    reg_write(3'd2, 2'b01, 16'h0000);
    reg_write(3'd1, 2'b01, 16'h0001);
    src[0] = 1'b1;
    tick(4);
    chk("lvl_ipl", 16'(ipl_n), 16'(3'b110));
    iack(3'd1, 3'b110, "ack_lvl");
    reg_read(3'd0, 16'h0001, "lvl_pending_kept");
    chk("lvl_ipl_kept", 16'(ipl_n), 16'(3'b110));
    reg_read(3'd4, 16'h0011, "lvl_status");
    reg_write(3'd0, 2'b01, 16'h0001);
    reg_read(3'd0, 16'h0001, "lvl_w1c_noeffect");
    src[0] = 1'b0;
    tick(2);
    chk("lvl_drop_early", 16'(ipl_n), 16'(3'b110));
    tick(1);
    chk("lvl_drop_ipl", 16'(ipl_n), 16'h7);
    reg_write(3'd2, 2'b01, 16'h007F);

    // 5: set wins over a same-cycle W1C, then a spurious ack
    reg_write(3'd1, 2'b01, 16'h0004);
    src[2] = 1'b1;
    tick(1);
    src[2] = 1'b0;
    tick(4);
    reg_read(3'd0, 16'h0004, "coll_pre");
    src[2] = 1'b1;
    tick(2);
    reg_write(3'd0, 2'b01, 16'h0004);
    reg_read(3'd0, 16'h0004, "coll_set_wins");
    reg_write(3'd0, 2'b01, 16'h0004);
    reg_read(3'd0, 16'h0000, "w1c_clears");
    src[2] = 1'b0;
    tick(2);
    iack(3'd3, 3'b111, "ack_spur");
    reg_read(3'd4, 16'h0130, "spur_status");
    iack(3'd0, 3'b111, "ack_lvl0");
    reg_read(3'd4, 16'h0200, "spur_lvl0");
    reg_write(3'd5, 2'b01, 16'h0000);
    reg_read(3'd4, 16'h0000, "spurclr");

    // 6: masking, force, then reset during HOLD
    reg_write(3'd1, 2'b01, 16'h0000);
    reg_write(3'd3, 2'b01, 16'h0008);
    reg_read(3'd0, 16'h0008, "force_pending");
    tick(1);
    chk("masked_ipl", 16'(ipl_n), 16'h7);
    reg_write(3'd1, 2'b01, 16'h0008);
    chk("unmask_early", 16'(ipl_n), 16'h7);
    tick(1);
    chk("unmask_ipl", 16'(ipl_n), 16'(3'b011));
    cpu_fc = 3'b111; cpu_lvl = 3'd4; cpu_as_n = 1'b0;
    tick(2);
    chk("hold_vpa", 16'(vpa_n), 16'h0);
    reset = 1'b1;
    tick(1);
    chk("rst_hold_vpa", 16'(vpa_n), 16'h1);
    chk("rst_hold_ipl", 16'(ipl_n), 16'h7);
    reset = 1'b0; cpu_as_n = 1'b1; cpu_fc = 3'b000;
    tick(1);
    reg_read(3'd0, 16'h0000, "rst_hold_pending");
    reg_read(3'd1, 16'h0000, "rst_hold_enable");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
